// File: rtl/serial_add_ctrl_if.sv
// Handshake and bit-serial adder bus for serial_add_ctrl.
// The slave side is the sequencer; the master side is the operand source plus the adder.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             fa_a;
    logic             fa_b;
    logic             fa_c;
    logic             fa_s;
    logic             fa_cr;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport slave (
        input  start, sub, cin, op_a, op_b, fa_s, fa_cr,
        output fa_a, fa_b, fa_c, busy, done, sum, cout, overflow
    );

    modport master (
        output start, sub, cin, op_a, op_b, fa_s, fa_cr,
        input  fa_a, fa_b, fa_c, busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer driving one shared external full adder.
// Each bit takes a DRIVE (settle) and a CAPTURE cycle, LSB first.
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    serial_add_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_sum;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             w_last;

    assign w_last = (r_idx == IDX_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (bus.start) w_next = S_DRIVE;
            S_DRIVE:   w_next = S_CAPTURE;
            S_CAPTURE: w_next = w_last ? S_DONE : S_DRIVE;
            S_DONE:    w_next = S_IDLE;
        endcase
    end

    // Result is loaded on the last capture edge, so it is already valid in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.op_a;
                        r_b     <= bus.sub ? ~bus.op_b : bus.op_b;
                        r_carry <= bus.sub ? 1'b1 : bus.cin;
                        r_idx   <= '0;
                    end
                end
                S_DRIVE: begin
                end
                S_CAPTURE: begin
                    r_work[r_idx] <= bus.fa_s;
                    r_carry       <= bus.fa_cr;
                    if (w_last) begin
                        r_sum  <= {bus.fa_s, r_work[WIDTH-2:0]};
                        r_cout <= bus.fa_cr;
                        r_ovf  <= r_carry ^ bus.fa_cr;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                end
            endcase
        end
    end

    always_comb begin
        bus.fa_a     = 1'b0;
        bus.fa_b     = 1'b0;
        bus.fa_c     = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.sum      = r_sum;
        bus.cout     = r_cout;
        bus.overflow = r_ovf;
        unique case (r_state)
            S_IDLE: begin
            end
            S_DRIVE, S_CAPTURE: begin
                bus.fa_a = r_a[r_idx];
                bus.fa_b = r_b[r_idx];
                bus.fa_c = r_carry;
                bus.busy = 1'b1;
            end
            S_DONE: begin
                bus.done = 1'b1;
            end
        endcase
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Sequencer that performs a WIDTH-bit add or subtract by time-multiplexing one external 1-bit full_adder, one bit per step, LSB first.
Latches operands on a start pulse, walks the bit index, feeds the adder, captures each sum bit and the ripple carry, then presents the word result with a one-cycle done strobe.
Sits between an operand source (CPU datapath or test driver) and a single shared full_adder instance.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
IDX_W, 3, bit-index counter width; must satisfy 2**IDX_W >= WIDTH

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  request; sampled only in IDLE
sub  in  1  0 = A+B+cin, 1 = A-B (cin ignored)
cin  in  1  carry-in for add
op_a  in  WIDTH  operand A
op_b  in  WIDTH  operand B
fa_a  out  1  to full_adder a
fa_b  out  1  to full_adder b
fa_c  out  1  to full_adder carry-in c
fa_s  in  1  from full_adder sum s
fa_cr  in  1  from full_adder carry-out cr
busy  out  1  high in DRIVE/CAPTURE
done  out  1  one-cycle strobe, result valid
sum  out  WIDTH  result word
cout  out  1  final carry-out (sub: 1 = no borrow)
overflow  out  1  signed overflow

Behaviour:
- Reset, synchronous, has priority over every other event. It forces state=IDLE, idx=0, carry=0, and sum, cout, overflow, done, busy, fa_a, fa_b, fa_c all = 0.
- States: IDLE, DRIVE, CAPTURE, DONE. All outputs are registered or decoded from registered state only. No combinational path exists from fa_s/fa_cr to outputs.
- IDLE: on start=1, load:
  - a_reg <= op_a
  - b_reg <= sub ? ~op_b : op_b
  - carry <= sub ? 1 : cin
  - idx <= 0
  - then go to DRIVE.
  - sum, cout and overflow hold their previous values until the next DONE.
- DRIVE: fa_a=a_reg[idx], fa_b=b_reg[idx], fa_c=carry. Next state is CAPTURE. This cycle gives the adder settle time.
- CAPTURE: fa_* hold the same values as in DRIVE. Register:
  - sum_work[idx] <= fa_s
  - carry <= fa_cr
  - if idx==WIDTH-1, also cmsb <= carry (the carry into the MSB, before update) and go to DONE
  - else idx <= idx+1 and go to DRIVE.
- DONE: one cycle only.
  - sum = sum_work, cout = carry, overflow = cmsb ^ carry. These are loaded on entry and held afterwards.
  - done=1 for exactly this cycle, then go to IDLE.
- fa_a, fa_b, fa_c = 0 in IDLE and DONE.
- Latency: start is sampled at edge 0. Bit k is driven in cycle 2k+1 and captured in cycle 2k+2. done is high in cycle 2*WIDTH+1 (17 for WIDTH=8). The next start is accepted in the cycle after done.
- start in DRIVE, CAPTURE or DONE is ignored. It is not queued.
- Operand or sub changes after the start sample have no effect on the operation in flight.
- idx never exceeds WIDTH-1. No wrap occurs during an operation.
- Reset mid-operation aborts the operation: no done is produced and sum/cout/overflow clear to 0.

Test Plan:
- WIDTH=8, bench full_adder wired to fa_*, op_a=0x05, op_b=0x03, sub=0, cin=0, start pulse -> done exactly 17 cycles later; sum=0x08, cout=0, overflow=0; busy high for 16 cycles.
- op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0. Repeat with op_a=0x7F -> sum=0x80, cout=0, overflow=1.
- sub=1, op_a=0x05, op_b=0x03 -> sum=0x02, cout=1. sub=1, op_a=0x03, op_b=0x05 -> sum=0xFE, cout=0, overflow=0. sub=1, op_a=0x80, op_b=0x01 -> sum=0x7F, overflow=1.
- cin=1, op_a=0x0F, op_b=0x00, sub=0 -> sum=0x10. Check per-bit fa_a/fa_b/fa_c sequence matches operand bits LSB-first, two cycles per bit.
- Start re-pulsed at cycles 3 and 17, and operands changed mid-operation -> first result unaffected, still exactly one done. Start re-pulsed at cycle 18 -> accepted.
- rst asserted at cycle 7 of an operation -> next cycle is IDLE with all outputs 0 and no done. A new start afterwards completes normally in 17 cycles.
